// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline constants, jump encoding and DE issue FSM state type.
package pipe_pkg;
    localparam int NREG  = 8;
    localparam int REG_W = $clog2(NREG);
    localparam int CNT_W = 2;
    localparam int ST_W  = 3;
    localparam logic [2:0] JMP_NONE = 3'b000;
    typedef enum logic {RUN, DRAIN} state_t;
endpackage

// File: rtl/de_issue_ctrl_sat_updown_cnt.sv
// sat_updown_cnt: saturating up/down counter with synchronous clear and zero/max flags.
module sat_updown_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         is_zero,
    output logic         is_max,
    output logic         nxt_zero
);
    logic [W-1:0] nxt;
    always_comb begin
        nxt = clr ? '0 :
              (inc && !dec && !is_max) ? cnt + 1'b1 :
              (dec && !inc && !is_zero) ? cnt - 1'b1 : cnt;
    end
    assign is_zero  = cnt == '0;
    assign is_max   = &cnt;
    assign nxt_zero = nxt == '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= nxt;
    end
    // A retire against an empty counter means the pipeline lost track of a write.
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(dec && !inc && !clr && is_zero));
endmodule

// File: rtl/de_issue_ctrl.sv
// de_issue_ctrl: DE->AG issue control with GPR write scoreboard, store counter and jump drain FSM.
// Define DE_ISSUE_BYPASS_EN to let WB forwarding clear dependencies and leave DRAIN one cycle early.
module de_issue_ctrl
    import pipe_pkg::*;
#(
    parameter int NREG  = pipe_pkg::NREG,
    parameter int CNT_W = pipe_pkg::CNT_W,
    parameter int ST_W  = pipe_pkg::ST_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    de_v,
    input  logic                    de_ro_needed,
    input  logic                    de_rm_needed,
    input  logic [$clog2(NREG)-1:0] de_ro_reg,
    input  logic [$clog2(NREG)-1:0] de_rm_reg,
    input  logic                    de_wr_reg_v,
    input  logic [$clog2(NREG)-1:0] de_wr_reg,
    input  logic                    de_re,
    input  logic                    de_we,
    input  logic [2:0]              de_jmp,
    input  logic                    mr_stall,
    input  logic                    mw_stall,
    input  logic                    wb_v,
    input  logic [$clog2(NREG)-1:0] wb_reg,
    input  logic                    st_done,
    input  logic                    flush,
    output logic                    reg_dep,
    output logic                    mem_dep,
    output logic                    ld_ag,
    output logic                    ag_vin,
    output logic                    issue,
    output logic                    sb_empty,
    output logic                    drain
);
    localparam int RW = $clog2(NREG);
    state_t state, state_nxt;
    logic [NREG-1:0][CNT_W-1:0] p_cnt;
    logic [NREG-1:0] p_inc, p_dec, p_zero, p_max, p_nzero;
    logic [ST_W-1:0] st_cnt;
    logic st_zero, st_max, st_nzero;
    logic ro_busy, rm_busy, jmp_block, drain_exit;
    logic unused;
    for (genvar i = 0; i < NREG; i++) begin : g_pend
        assign p_inc[i] = issue && de_wr_reg_v && de_wr_reg == RW'(i);
        assign p_dec[i] = wb_v && wb_reg == RW'(i);
        sat_updown_cnt #(.W(CNT_W)) u_cnt (
            .clk(clk), .rst_n(rst_n), .inc(p_inc[i]), .dec(p_dec[i]), .clr(flush),
            .cnt(p_cnt[i]), .is_zero(p_zero[i]), .is_max(p_max[i]), .nxt_zero(p_nzero[i])
        );
    end
    sat_updown_cnt #(.W(ST_W)) u_st (
        .clk(clk), .rst_n(rst_n), .inc(issue && de_we), .dec(st_done), .clr(flush),
        .cnt(st_cnt), .is_zero(st_zero), .is_max(st_max), .nxt_zero(st_nzero)
    );
    assign unused = &{1'b0, st_cnt, p_cnt, p_nzero, st_nzero};
`ifdef DE_ISSUE_BYPASS_EN
    // The last outstanding write retiring now is forwarded by WB, so it no longer blocks.
    assign ro_busy    = !p_zero[de_ro_reg] && !(wb_v && wb_reg == de_ro_reg && p_cnt[de_ro_reg] == CNT_W'(1));
    assign rm_busy    = !p_zero[de_rm_reg] && !(wb_v && wb_reg == de_rm_reg && p_cnt[de_rm_reg] == CNT_W'(1));
    assign drain_exit = &p_nzero && st_nzero;
`else
    assign ro_busy    = !p_zero[de_ro_reg];
    assign rm_busy    = !p_zero[de_rm_reg];
    assign drain_exit = sb_empty;
`endif
    assign sb_empty = &p_zero && st_zero;
    assign drain    = state == DRAIN;
    assign reg_dep  = de_v && ((de_ro_needed && ro_busy) || (de_rm_needed && rm_busy) ||
                               (de_wr_reg_v && p_max[de_wr_reg]));
    assign mem_dep  = de_v && ((de_re && !st_zero) || (de_we && st_max));
    assign ld_ag    = !(mem_dep || mr_stall || mw_stall);
    assign ag_vin   = de_v && !reg_dep && !jmp_block;
    assign issue    = ag_vin && ld_ag && !flush;
    always_comb begin
        jmp_block = drain || (de_v && de_jmp != JMP_NONE && !sb_empty);
        state_nxt = flush ? RUN :
                    !drain ? (jmp_block ? DRAIN : RUN) :
                    (!de_v || drain_exit) ? RUN : DRAIN;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end
endmodule
